// File: rtl/bp_fe_fetch_buffer.sv
// rtl/bp_fe_fetch_buffer.sv - multi-lane fetch/exception decoupling buffer ahead of the FE queue
module bp_fe_fetch_buffer #(
    parameter int els_p            = 8,
    parameter int enq_width_p      = 2,
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int metadata_width_p = 36
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    flush_i,

    input  logic [enq_width_p-1:0]                  enq_v_i,
    input  logic [enq_width_p*vaddr_width_p-1:0]    enq_pc_i,
    input  logic [enq_width_p*instr_width_p-1:0]    enq_instr_i,
    input  logic [enq_width_p*metadata_width_p-1:0] enq_metadata_i,
    input  logic [enq_width_p-1:0]                  enq_exc_i,
    input  logic [enq_width_p*2-1:0]                enq_exc_code_i,
    output logic                                    enq_ready_o,

    output logic                                    deq_v_o,
    output logic [vaddr_width_p-1:0]                deq_pc_o,
    output logic [instr_width_p-1:0]                deq_instr_o,
    output logic [metadata_width_p-1:0]             deq_metadata_o,
    output logic                                    deq_exc_o,
    output logic [1:0]                              deq_exc_code_o,
    input  logic                                    deq_yumi_i,

    output logic                                    halted_o,
    output logic [$clog2(els_p+1)-1:0]              count_o
);

    localparam int ptr_w_lp      = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp      = $clog2(els_p + 1);
    localparam int lane_cnt_w_lp = $clog2(enq_width_p + 1);

    // Highest occupancy at which a full-width packet still fits.
    localparam logic [cnt_w_lp-1:0] ready_max_lp = cnt_w_lp'(els_p - enq_width_p);

    // Entry storage, one array per field; no reset needed since count gates validity.
    logic [vaddr_width_p-1:0]    pc_mem    [els_p];
    logic [instr_width_p-1:0]    instr_mem [els_p];
    logic [metadata_width_p-1:0] meta_mem  [els_p];
    logic                        exc_mem   [els_p];
    logic [1:0]                  code_mem  [els_p];

    logic [ptr_w_lp-1:0]      head_r;
    logic [ptr_w_lp-1:0]      tail_r;
    logic [cnt_w_lp-1:0]      count_r;
    logic                     halted_r;

    logic [enq_width_p-1:0]   lane_acc;
    logic [lane_cnt_w_lp-1:0] acc_n;
    logic                     lane_stop;
    logic [ptr_w_lp-1:0]      wr_idx [enq_width_p];

    logic                     enq_fire;
    logic                     deq_fire;
    logic                     exc_accepted;
    logic [cnt_w_lp-1:0]      enq_add;
    logic [cnt_w_lp-1:0]      deq_sub;

    // Ready is all-or-nothing on the current occupancy; a same-cycle dequeue does not help.
    assign enq_ready_o = ~halted_r & ~reset_i & (count_r <= ready_max_lp);
    assign enq_fire    = enq_v_i[0] & enq_ready_o & ~flush_i;
    assign deq_fire    = deq_yumi_i & ~flush_i & (count_r != '0);

    // Accept valid lanes in order, stopping after the first exception lane or the first invalid lane.
    always_comb begin
        lane_acc  = '0;
        acc_n     = '0;
        lane_stop = 1'b0;
        for (int i = 0; i < enq_width_p; i++) begin
            if (!lane_stop && enq_v_i[i]) begin
                lane_acc[i] = 1'b1;
                acc_n       = acc_n + lane_cnt_w_lp'(1);
                if (enq_exc_i[i]) begin
                    lane_stop = 1'b1;
                end
            end else begin
                lane_stop = 1'b1;
            end
        end
    end

    // Lane i lands i slots past the tail; the power-of-two depth makes the wrap free.
    always_comb begin
        for (int i = 0; i < enq_width_p; i++) begin
            wr_idx[i] = tail_r + ptr_w_lp'(i);
        end
    end

    assign exc_accepted = |(lane_acc & enq_exc_i);
    assign enq_add      = enq_fire ? cnt_w_lp'(acc_n) : '0;
    assign deq_sub      = cnt_w_lp'(deq_fire);

    // Write accepted lanes into storage.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            for (int i = 0; i < enq_width_p; i++) begin
                if (lane_acc[i]) begin
                    pc_mem[wr_idx[i]]    <= enq_pc_i[i*vaddr_width_p +: vaddr_width_p];
                    instr_mem[wr_idx[i]] <= enq_instr_i[i*instr_width_p +: instr_width_p];
                    meta_mem[wr_idx[i]]  <= enq_metadata_i[i*metadata_width_p +: metadata_width_p];
                    exc_mem[wr_idx[i]]   <= enq_exc_i[i];
                    code_mem[wr_idx[i]]  <= enq_exc_code_i[i*2 +: 2];
                end
            end
        end
    end

    // Pointer, occupancy and halt bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            halted_r <= 1'b0;
        end else begin
            if (deq_fire) begin
                head_r <= head_r + ptr_w_lp'(1);
            end
            if (enq_fire) begin
                tail_r <= tail_r + ptr_w_lp'(acc_n);
            end
            count_r  <= count_r + enq_add - deq_sub;
            halted_r <= halted_r | (enq_fire & exc_accepted);
        end
    end

    assign deq_v_o        = (count_r != '0);
    assign deq_pc_o       = pc_mem[head_r];
    assign deq_instr_o    = instr_mem[head_r];
    assign deq_metadata_o = meta_mem[head_r];
    assign deq_exc_o      = exc_mem[head_r];
    assign deq_exc_code_o = code_mem[head_r];
    assign halted_o       = halted_r;
    assign count_o        = count_r;

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// tb/tb_bp_fe_fetch_buffer.sv - self-checking bench for bp_fe_fetch_buffer
module tb_bp_fe_fetch_buffer;

    localparam int ELS = 8;
    localparam int W   = 2;
    localparam int VA  = 39;
    localparam int IW  = 32;
    localparam int MW  = 36;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              flush_i;
    logic [W-1:0]      enq_v_i;
    logic [W*VA-1:0]   enq_pc_i;
    logic [W*IW-1:0]   enq_instr_i;
    logic [W*MW-1:0]   enq_metadata_i;
    logic [W-1:0]      enq_exc_i;
    logic [W*2-1:0]    enq_exc_code_i;
    logic              enq_ready_o;
    logic              deq_v_o;
    logic [VA-1:0]     deq_pc_o;
    logic [IW-1:0]     deq_instr_o;
    logic [MW-1:0]     deq_metadata_o;
    logic              deq_exc_o;
    logic [1:0]        deq_exc_code_o;
    logic              deq_yumi_i;
    logic              halted_o;
    logic [3:0]        count_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic [MW-1:0] meta;
        logic          exc;
        logic [1:0]    code;
    } entry_t;

    entry_t m_q[$];
    logic   m_halted;

    bp_fe_fetch_buffer #(
        .els_p(ELS), .enq_width_p(W), .vaddr_width_p(VA),
        .instr_width_p(IW), .metadata_width_p(MW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .enq_v_i(enq_v_i), .enq_pc_i(enq_pc_i), .enq_instr_i(enq_instr_i),
        .enq_metadata_i(enq_metadata_i), .enq_exc_i(enq_exc_i),
        .enq_exc_code_i(enq_exc_code_i), .enq_ready_o(enq_ready_o),
        .deq_v_o(deq_v_o), .deq_pc_o(deq_pc_o), .deq_instr_o(deq_instr_o),
        .deq_metadata_o(deq_metadata_o), .deq_exc_o(deq_exc_o),
        .deq_exc_code_o(deq_exc_code_o), .deq_yumi_i(deq_yumi_i),
        .halted_o(halted_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_i) begin
            assert (!(enq_v_i[1] && !enq_v_i[0]))
                else $error("FAIL thermometer enq_v_i=%b", enq_v_i);
        end
    end

    // Reference: a FIFO of entries plus a halt bit, advanced from the rules of the block.
    task automatic model_update();
        bit ready;
        ready = !m_halted && !reset_i && ((ELS - m_q.size()) >= W);
        if (reset_i || flush_i) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (deq_yumi_i && m_q.size() > 0) void'(m_q.pop_front());
            if (enq_v_i[0] && ready) begin
                for (int l = 0; l < W; l++) begin
                    entry_t e;
                    if (!enq_v_i[l]) break;
                    e.pc    = enq_pc_i[l*VA +: VA];
                    e.instr = enq_instr_i[l*IW +: IW];
                    e.meta  = enq_metadata_i[l*MW +: MW];
                    e.exc   = enq_exc_i[l];
                    e.code  = enq_exc_code_i[l*2 +: 2];
                    m_q.push_back(e);
                    if (e.exc) begin
                        m_halted = 1'b1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_i        = 1'b0;
        flush_i        = 1'b0;
        enq_v_i        = '0;
        enq_pc_i       = '0;
        enq_instr_i    = '0;
        enq_metadata_i = '0;
        enq_exc_i      = '0;
        enq_exc_code_i = '0;
        deq_yumi_i     = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [VA-1:0] pc, input logic exc, input logic [1:0] code);
        enq_v_i[l]               = 1'b1;
        enq_pc_i[l*VA +: VA]     = pc;
        enq_instr_i[l*IW +: IW]  = IW'($urandom);
        enq_metadata_i[l*MW +: MW] = {4'($urandom), 32'($urandom)};
        enq_exc_i[l]             = exc;
        enq_exc_code_i[l*2 +: 2] = code;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic push_normal(input int lanes, input logic [VA-1:0] pc0, input logic [VA-1:0] pc1);
        idle_inputs();
        set_lane(0, pc0, 1'b0, 2'd0);
        if (lanes > 1) set_lane(1, pc1, 1'b0, 2'd0);
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_during got=%b exp=0", enq_ready_o); end
        checks++;
        if (count_o !== 4'd0 || deq_v_o !== 1'b0 || halted_o !== 1'b0) begin
            errors++; $display("FAIL reset_state got count=%0d v=%b h=%b exp 0 0 0", count_o, deq_v_o, halted_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", enq_ready_o); end
    endtask

    task automatic test_fill_drain();
        do_flush();
        for (int p = 0; p < 4; p++) push_normal(2, VA'(32'h1000 + 4*p), VA'(32'h1002 + 4*p));
        checks++;
        if (count_o !== 4'd8 || enq_ready_o !== 1'b0) begin
            errors++; $display("FAIL fill_full got count=%0d ready=%b exp 8 0", count_o, enq_ready_o);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (deq_v_o !== 1'b1 || deq_pc_o !== VA'(32'h1000 + 2*k)) begin
                errors++; $display("FAIL drain_pc[%0d] got v=%b pc=%h exp 1 %h", k, deq_v_o, deq_pc_o, 32'h1000 + 2*k);
            end
            deq_yumi_i = 1'b1;
            step();
        end
        deq_yumi_i = 1'b0;
        checks++;
        if (deq_v_o !== 1'b0) begin errors++; $display("FAIL drain_empty got v=%b exp 0", deq_v_o); end
    endtask

    task automatic test_exception();
        do_flush();
        set_lane(0, VA'(32'h3000), 1'b1, 2'd1);
        set_lane(1, VA'(32'h3004), 1'b0, 2'd0);
        step();
        idle_inputs();
        checks++;
        if (count_o !== 4'd1 || deq_exc_o !== 1'b1 || deq_exc_code_o !== 2'd1) begin
            errors++; $display("FAIL exc_entry got count=%0d exc=%b code=%0d exp 1 1 1", count_o, deq_exc_o, deq_exc_code_o);
        end
        checks++;
        if (halted_o !== 1'b1 || enq_ready_o !== 1'b0) begin
            errors++; $display("FAIL exc_halt got halted=%b ready=%b exp 1 0", halted_o, enq_ready_o);
        end
        push_normal(1, VA'(32'h3008), '0);
        checks++;
        if (count_o !== 4'd1) begin errors++; $display("FAIL exc_halt_blocks got count=%0d exp 1", count_o); end
        deq_yumi_i = 1'b1;
        step();
        deq_yumi_i = 1'b0;
        checks++;
        if (deq_v_o !== 1'b0 || halted_o !== 1'b1) begin
            errors++; $display("FAIL exc_lane1_dropped got v=%b halted=%b exp 0 1", deq_v_o, halted_o);
        end
    endtask

    task automatic test_flush_priority();
        do_flush();
        push_normal(2, VA'(32'h10), VA'(32'h14));
        push_normal(2, VA'(32'h18), VA'(32'h1c));
        push_normal(1, VA'(32'h20), '0);
        checks++;
        if (count_o !== 4'd5) begin errors++; $display("FAIL flush_setup got count=%0d exp 5", count_o); end
        set_lane(0, VA'(32'h24), 1'b0, 2'd0);
        set_lane(1, VA'(32'h28), 1'b0, 2'd0);
        deq_yumi_i = 1'b1;
        flush_i    = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (count_o !== 4'd0 || deq_v_o !== 1'b0 || halted_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_priority got count=%0d v=%b h=%b r=%b exp 0 0 0 1",
                               count_o, deq_v_o, halted_o, enq_ready_o);
        end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int k = 0; k < 7; k++) begin
            push_normal(1, VA'(32'h500 + k), '0);
            deq_yumi_i = 1'b1;
            step();
            deq_yumi_i = 1'b0;
        end
        push_normal(2, VA'(32'h2000), VA'(32'h2004));
        checks++;
        if (count_o !== 4'd2 || deq_pc_o !== VA'(32'h2000)) begin
            errors++; $display("FAIL wrap_first got count=%0d pc=%h exp 2 2000", count_o, deq_pc_o);
        end
        deq_yumi_i = 1'b1;
        step();
        checks++;
        if (deq_v_o !== 1'b1 || deq_pc_o !== VA'(32'h2004)) begin
            errors++; $display("FAIL wrap_second got v=%b pc=%h exp 1 2004", deq_v_o, deq_pc_o);
        end
        step();
        deq_yumi_i = 1'b0;
        checks++;
        if (count_o !== 4'd0) begin errors++; $display("FAIL wrap_empty got count=%0d exp 0", count_o); end
    endtask

    task automatic test_back_to_back();
        do_flush();
        for (int p = 0; p < 3; p++) push_normal(2, VA'(32'h40 + 8*p), VA'(32'h44 + 8*p));
        set_lane(0, VA'(32'h70), 1'b0, 2'd0);
        set_lane(1, VA'(32'h74), 1'b0, 2'd0);
        deq_yumi_i = 1'b1;
        step();
        checks++;
        if (count_o !== 4'd7) begin errors++; $display("FAIL simul_count6 got count=%0d exp 7", count_o); end
        checks++;
        if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL simul_ready7 got ready=%b exp 0", enq_ready_o); end
        step();
        idle_inputs();
        checks++;
        if (count_o !== 4'd6) begin errors++; $display("FAIL simul_count7 got count=%0d exp 6", count_o); end
    endtask

    task automatic test_reset_mid();
        do_flush();
        push_normal(2, VA'(32'h80), VA'(32'h84));
        set_lane(0, VA'(32'h88), 1'b0, 2'd0);
        set_lane(1, VA'(32'h8c), 1'b1, 2'd3);
        step();
        idle_inputs();
        checks++;
        if (count_o !== 4'd4 || halted_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup got count=%0d halted=%b exp 4 1", count_o, halted_o);
        end
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 4'd0 || halted_o !== 1'b0 || deq_v_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got count=%0d h=%b v=%b r=%b exp 0 0 0 1",
                               count_o, halted_o, deq_v_o, enq_ready_o);
        end
    endtask

    task automatic test_random();
        bit exp_ready;
        do_flush();
        for (int n = 0; n < 600; n++) begin
            exp_ready = !m_halted && ((ELS - m_q.size()) >= W);
            checks++;
            if (count_o !== 4'(m_q.size()) || halted_o !== m_halted || enq_ready_o !== exp_ready
                || deq_v_o !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_status[%0d] got c=%0d h=%b r=%b v=%b exp c=%0d h=%b r=%b v=%b", n,
                         count_o, halted_o, enq_ready_o, deq_v_o, m_q.size(), m_halted, exp_ready, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (deq_pc_o !== m_q[0].pc || deq_instr_o !== m_q[0].instr || deq_metadata_o !== m_q[0].meta
                    || deq_exc_o !== m_q[0].exc || (m_q[0].exc && deq_exc_code_o !== m_q[0].code)) begin
                    errors++;
                    $display("FAIL rand_head[%0d] got pc=%h exc=%b code=%0d exp pc=%h exc=%b code=%0d", n,
                             deq_pc_o, deq_exc_o, deq_exc_code_o, m_q[0].pc, m_q[0].exc, m_q[0].code);
                end
            end
            idle_inputs();
            case ($urandom_range(0, 2))
                1: set_lane(0, VA'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom));
                2: begin
                    set_lane(0, VA'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom));
                    set_lane(1, VA'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom));
                end
                default: ;
            endcase
            deq_yumi_i = (m_q.size() != 0) && ($urandom_range(0, 2) != 0);
            flush_i    = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        m_halted = 1'b0;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_exception();
        test_flush_priority();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_buffer.md
# bp_fe_fetch_buffer

Parametrised multi-lane decoupling buffer between front-end fetch and the FE queue. It accepts up to `enq_width_p` fetched instructions or exceptions per cycle and retires one per cycle to the backend. It halts fetch after an exception entry and discards all contents on a redirect flush. It supersedes the single-entry fetch/exception path feeding the FE queue and allows wider fetch without a wider FE queue.

## Interface
Parameters:
- `els_p`, 8: buffer depth in entries; power of two, must be ≥ `enq_width_p`.
- `enq_width_p`, 2: enqueue lanes per cycle; ≥ 1.
- `vaddr_width_p`, 39: PC width.
- `instr_width_p`, 32: instruction width.
- `metadata_width_p`, 36: branch metadata forward width.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard all entries and clear halt.
- `enq_v_i` in `enq_width_p`: lane valids.
- `enq_pc_i` in `enq_width_p*vaddr_width_p`: lane PCs; lane 0 in the LSBs.
- `enq_instr_i` in `enq_width_p*instr_width_p`: lane instructions.
- `enq_metadata_i` in `enq_width_p*metadata_width_p`: lane metadata.
- `enq_exc_i` in `enq_width_p`: lane is an exception entry.
- `enq_exc_code_i` in `enq_width_p*2`: exception code per lane; 0 itlb miss, 1 page fault, 2 access fault, 3 icache miss.
- `enq_ready_o` out 1: whole packet can be accepted.
- `deq_v_o` out 1: head entry valid.
- `deq_pc_o` out `vaddr_width_p`: head PC.
- `deq_instr_o` out `instr_width_p`: head instruction.
- `deq_metadata_o` out `metadata_width_p`: head metadata.
- `deq_exc_o` out 1: head entry is an exception.
- `deq_exc_code_o` out 2: head exception code.
- `deq_yumi_i` in 1: consume head; legal only when `deq_v_o` is high.
- `halted_o` out 1: exception captured; no further enqueue.
- `count_o` out `$clog2(els_p+1)`: occupied entries.

## Operation
- Circular storage of `els_p` entries. State: head pointer and tail pointer (`$clog2(els_p)` bits each, wrapping modulo `els_p`), count, and halt flag.
- `enq_v_i` must be thermometer-coded from lane 0. A non-contiguous pattern is illegal; the bench asserts on it.
- `enq_ready_o` = `~halted_o & ~reset_i & (els_p - count >= enq_width_p)`. It is all-or-nothing and does not look through a same-cycle dequeue.
- Enqueue fires when `enq_v_i[0] & enq_ready_o & ~flush_i`.
  - Accepted lanes are the valid lanes up to and including the lowest lane with `enq_exc_i` set. Valid lanes above that lane are dropped.
  - Accepted lanes are written in lane order starting at the tail. The tail advances by the number of accepted lanes, modulo `els_p`.
  - If any lane is accepted as an exception, the halt flag is set.
- Dequeue fires when `deq_yumi_i & ~flush_i`. The head advances by 1.
- Count update: next count = count + accepted − dequeued. Simultaneous enqueue and dequeue are both honoured.
- `flush_i` has priority over enqueue and dequeue in the same cycle. It zeros head, tail, count and halt.
- `deq_*` outputs read combinationally from the head entry. Payload is don't-care when `deq_v_o` is low.
- `deq_v_o` = (count != 0).

## Timing
- Reset values: `count_o`=0, `deq_v_o`=0, `halted_o`=0, `enq_ready_o`=0 while `reset_i` is high and 1 in the first cycle after reset. Head and tail pointers reset to 0.
- Latency: an entry enqueued at edge N is visible on `deq_*` in cycle N+1. There is no enqueue-to-dequeue bypass.
- Throughput: up to `enq_width_p` in and 1 out per cycle.
- Full buffer with a same-cycle dequeue: the enqueue is still refused, because ready uses the current count.
- Wrap-around: a packet that straddles index `els_p-1` continues at index 0.
- Reset or flush mid-packet: nothing from that cycle is written.
- A halt persists until `flush_i` or `reset_i`. Dequeue continues while halted, so the exception entry drains normally.

## Test plan
- Basic fill/drain: `els_p`=8, `enq_width_p`=2; enqueue 4 packets with PCs 0x1000..0x100E in steps of 2, no yumi.
  - After the fourth packet: `count_o`=8, `enq_ready_o`=0.
  - Then yumi every cycle: PCs emerge in order 0x1000, 0x1002, …, 0x100E, and `deq_v_o` drops after the 8th.
- Exception truncation: `enq_v_i`=2'b11, `enq_exc_i`=2'b01, code 1 at count 0.
  - Next cycle: `count_o`=1, `deq_exc_o`=1, `deq_exc_code_o`=1, `halted_o`=1, `enq_ready_o`=0.
  - Lane 1 is never dequeued.
- Flush priority: with count 5, drive `flush_i`, a valid packet and `deq_yumi_i` in the same cycle.
  - Next cycle: `count_o`=0, `deq_v_o`=0, `halted_o`=0, `enq_ready_o`=1.
- Wrap-around: advance head/tail to 7 by enqueuing 7 single-lane entries and dequeuing 7.
  - Then enqueue PCs 0x2000 and 0x2004 in one packet; dequeue order is 0x2000 then 0x2004, and `count_o` returns to 0.
- Simultaneous enqueue/dequeue at count 6: a 2-lane enqueue plus yumi in the same cycle gives `count_o`=7.
  - At count 7 with yumi: `enq_ready_o`=0, and count goes to 6.
- Reset mid-stream: assert `reset_i` for 1 cycle at count 4 while `halted_o`=1.
  - Next cycle: `count_o`=0, `halted_o`=0, `deq_v_o`=0, `enq_ready_o`=1.
